// File: rtl/toggle_cover_scheduler.sv
// Toggle-coverage scheduler: captures toggle hits into a sticky pending map, then
// emits each newly hit point once, lowest index first, over a valid/ready channel.
module toggle_cover_scheduler #(
  parameter int     WIDTH       = 65,
  parameter longint COVER_INDEX = 0,
  parameter longint COVER_TOTAL = 38253,
  parameter int     IDX_W       = 64,
  localparam int    CW          = $clog2(WIDTH + 1),
  localparam int    KW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CW-1:0]    covered_cnt,
  output logic [CW-1:0]    pending_cnt,
  output logic             clear_busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  generate
    if (COVER_INDEX + longint'(WIDTH) > COVER_TOTAL) begin : g_range_err
      $error("toggle_cover_scheduler: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
  endgenerate

  // Output channel: out_valid/out_index form one beat; a beat moves on any edge where
  // out_valid & out_ready, and both hold stable while out_valid=1 and out_ready=0.
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_WIPE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] p_map, c_map, new_hits, lowest;
  logic [KW-1:0]    k_idx;
  logic             capture_en, load_ok, wipe, load, xfer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nx;
  end

  // A clear sampled in RUN already blocks capture and load on that edge.
  always_comb begin
    state_nx   = state;
    capture_en = 1'b0;
    load_ok    = 1'b0;
    wipe       = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (clear) begin
          state_nx = ST_DRAIN;
        end else begin
          capture_en = enable;
          load_ok    = 1'b1;
        end
      end
      ST_DRAIN: if (!out_valid || out_ready) state_nx = ST_WIPE;
      ST_WIPE: begin
        wipe     = 1'b1;
        state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Two's-complement trick isolates the lowest pending bit; the loop encodes it.
  always_comb begin
    lowest = p_map & (~p_map + WIDTH'(1));
    k_idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) k_idx = KW'(i);
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < WIDTH; i++) pending_cnt = pending_cnt + CW'(p_map[i]);
  end

  assign new_hits = capture_en ? (valid & ~c_map & ~p_map) : '0;
  assign load     = load_ok && (|p_map) && (!out_valid || out_ready);
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_map       <= '0;
      c_map       <= '0;
      covered_cnt <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
    end else begin
      if (wipe) begin
        p_map       <= '0;
        c_map       <= '0;
        covered_cnt <= '0;
      end else begin
        p_map <= (p_map & ~({WIDTH{load}} & lowest)) | new_hits;
        if (load) begin
          c_map       <= c_map | lowest;
          covered_cnt <= covered_cnt + CW'(1);
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_index <= IDX_W'(COVER_INDEX) + IDX_W'(k_idx);
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign clear_busy = (state != ST_RUN);
  assign done       = (covered_cnt == CW'(WIDTH));
  assign state_dbg  = state;

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Bench for toggle_cover_scheduler: directed scenarios with literal expectations plus
// a randomized run, all compared each cycle against a point-set reference model.
module tb_toggle_cover_scheduler;

  localparam int WIDTH = 65;
  localparam int CIDX  = 100;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             enable    = 1'b0;
  logic [WIDTH-1:0] valid     = '0;
  logic             clear     = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [63:0]      out_index;
  logic [6:0]       covered_cnt, pending_cnt;
  logic             clear_busy, done;
  logic [1:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  toggle_cover_scheduler #(.WIDTH(WIDTH), .COVER_INDEX(CIDX)) dut (
    .clock(clock), .reset(reset), .enable(enable), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_cnt(covered_cnt), .pending_cnt(pending_cnt), .clear_busy(clear_busy),
    .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: sets of pending/covered points and a one-entry output slot;
  // m_phase 0 = accepting, 1 = waiting for slot to empty, 2 = forgetting everything
  bit m_pend[WIDTH];
  bit m_cov[WIDTH];
  bit m_new[WIDTH];
  bit m_ov    = 1'b0;
  int m_idx   = 0;
  int m_phase = 0;
  int m_k;
  bit m_xfer;

  function automatic int count_set(bit a[WIDTH]);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(a[i]);
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_pend[i] = 1'b0;
        m_cov[i]  = 1'b0;
      end
      m_ov = 1'b0; m_idx = 0; m_phase = 0;
    end else begin
      m_xfer = m_ov && out_ready;
      case (m_phase)
        0: begin
          if (clear) begin
            m_phase = 1;
            if (m_xfer) m_ov = 1'b0;
          end else begin
            for (int i = 0; i < WIDTH; i++)
              m_new[i] = enable && valid[i] && !m_pend[i] && !m_cov[i];
            m_k = -1;
            for (int i = 0; i < WIDTH; i++)
              if (m_pend[i] && m_k < 0) m_k = i;
            if (m_k >= 0 && (!m_ov || out_ready)) begin
              m_pend[m_k] = 1'b0;
              m_cov[m_k]  = 1'b1;
              m_ov        = 1'b1;
              m_idx       = CIDX + m_k;
            end else if (m_xfer) begin
              m_ov = 1'b0;
            end
            for (int i = 0; i < WIDTH; i++)
              if (m_new[i]) m_pend[i] = 1'b1;
          end
        end
        1: begin
          if (!m_ov || out_ready) m_phase = 2;
          if (m_xfer) m_ov = 1'b0;
        end
        default: begin
          for (int i = 0; i < WIDTH; i++) begin
            m_pend[i] = 1'b0;
            m_cov[i]  = 1'b0;
          end
          m_phase = 0;
        end
      endcase
    end
  end

  // compare process + beat monitor (negedge: away from the active edge)
  always @(negedge clock) begin
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_index", out_index, 64'(m_idx));
    chk("covered_cnt", covered_cnt, 64'(count_set(m_cov)));
    chk("pending_cnt", pending_cnt, 64'(count_set(m_pend)));
    chk("clear_busy", clear_busy, m_phase != 0);
    chk("done", done, count_set(m_cov) == WIDTH);
    if (reset && out_valid && out_ready) got_q.push_back(out_index);
  end

  // driver tasks
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_clear();
    valid = '0; out_ready = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    step(4);
    chk("clear_done_busy", clear_busy, 1'b0);
    got_q.delete();
  endtask

  task automatic check_beats(string name);
    chk({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_beat"}, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    step(2);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_covered", covered_cnt, 0);
    reset = 1'b1; enable = 1'b1;
    step();

    // 1: single hit, latency
    got_q.delete();
    out_ready = 1'b1; valid = '0; valid[3] = 1'b1;
    step();
    valid = '0;
    step();
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_index", out_index, 103);
    step(4);
    exp_q.push_back(103);
    check_beats("t1");
    chk("t1_covered", covered_cnt, 1);

    // 2: all points at once
    do_clear();
    valid = '1;
    step();
    valid = '0;
    step(70);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(64'(CIDX + i));
    check_beats("t2");
    chk("t2_done", done, 1'b1);
    chk("t2_pending", pending_cnt, 0);
    chk("t2_out_valid", out_valid, 1'b0);

    // 3: backpressure hold
    do_clear();
    out_ready = 1'b0; valid[2] = 1'b1; valid[9] = 1'b1;
    step();
    valid = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_index", out_index, 102);
    end
    out_ready = 1'b1;
    step();
    chk("t3_next_index", out_index, 109);
    step(3);
    exp_q.push_back(102); exp_q.push_back(109);
    check_beats("t3");

    // 4: held / repeated hit emits once
    do_clear();
    valid[7] = 1'b1;
    step(20);
    valid = '0;
    step(5);
    valid[7] = 1'b1;
    step();
    valid = '0;
    step(5);
    exp_q.push_back(107);
    check_beats("t4");
    chk("t4_covered", covered_cnt, 1);

    // 5: clear while a beat is stalled
    do_clear();
    out_ready = 1'b0; valid[7] = 1'b1; valid[8] = 1'b1;
    step();
    valid = '0;
    step(2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_busy", clear_busy, 1'b1);
      chk("t5_hold_index", out_index, 107);
    end
    out_ready = 1'b1;
    step();
    chk("t5_wipe_busy", clear_busy, 1'b1);
    step();
    chk("t5_run_busy", clear_busy, 1'b0);
    chk("t5_covered", covered_cnt, 0);
    chk("t5_pending", pending_cnt, 0);
    step(3);
    valid[7] = 1'b1;
    step();
    valid = '0;
    step(4);
    exp_q.push_back(107); exp_q.push_back(107);
    check_beats("t5");

    // 6: asynchronous reset mid-burst
    do_clear();
    valid = '1;
    step();
    valid = '0;
    step(11);
    #1 reset = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_covered", covered_cnt, 0);
    chk("t6_busy", clear_busy, 1'b0);
    chk("t6_pending", pending_cnt, 0);
    step();
    reset = 1'b1;
    step();
    valid = '1;
    step();
    valid = '0;
    step();
    chk("t6_restart_index", out_index, 100);
    step(70);
    chk("t6_done", done, 1'b1);

    // randomized run
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) v[i] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) v = '1;
      valid     = v;
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      step();
    end
    valid = '0; clear = 1'b0; out_ready = 1'b1;
    step(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
